// File: rtl/irrigation_zone_timer_pkg.sv
// Shared types and digit constants for the multi-zone irrigation countdown timer.
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } zone_state_t;

    localparam int unsigned MIN_D_W   = 2;
    localparam int unsigned MIN_U_W   = 4;
    localparam int unsigned SEC_D_W   = 3;
    localparam int unsigned SEC_U_W   = 4;
    localparam int unsigned SEC_D_MAX = 5;
    localparam int unsigned BCD_MAX   = 9;

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// mm:ss BCD down counter for one zone; clear beats load beats decrement.
module bcd_mmss_down_counter
    import irrigation_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               dec,
    input  logic [MIN_D_W-1:0] load_min_d,
    input  logic [MIN_U_W-1:0] load_min_u,
    output logic [MIN_D_W-1:0] min_d,
    output logic [MIN_U_W-1:0] min_u,
    output logic [SEC_D_W-1:0] sec_d,
    output logic [SEC_U_W-1:0] sec_u,
    output logic               zero,
    output logic               last
);

    assign zero = (min_d == '0) && (min_u == '0) && (sec_d == '0) && (sec_u == '0);
    // last: the next decrement lands on 00:00
    assign last = (min_d == '0) && (min_u == '0) && (sec_d == '0) && (sec_u == SEC_U_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_d <= '0;
            min_u <= '0;
            sec_d <= '0;
            sec_u <= '0;
        end else if (clear) begin
            min_d <= '0;
            min_u <= '0;
            sec_d <= '0;
            sec_u <= '0;
        end else if (load) begin
            min_d <= load_min_d;
            min_u <= load_min_u;
            sec_d <= '0;
            sec_u <= '0;
        end else if (dec && !zero) begin
            if (sec_u != '0) begin
                sec_u <= sec_u - SEC_U_W'(1);
            end else begin
                sec_u <= SEC_U_W'(BCD_MAX);
                if (sec_d != '0) begin
                    sec_d <= sec_d - SEC_D_W'(1);
                end else begin
                    sec_d <= SEC_D_W'(SEC_D_MAX);
                    if (min_u != '0) begin
                        min_u <= min_u - MIN_U_W'(1);
                    end else begin
                        min_u <= MIN_U_W'(BCD_MAX);
                        min_d <= min_d - MIN_D_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_timer.sv
// ZONES independent mm:ss countdown timers sharing a one-second prescaler.
// Optional per-zone pause input enabled by IRRIGATION_TIMER_PAUSE_EN.
module irrigation_zone_timer
    import irrigation_timer_pkg::*;
#(
    parameter int unsigned ZONES    = 2,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ZONES-1:0]       irrigation_on,
    input  logic [ZONES-1:0]       switch_pulse,
    input  logic [ZONES-1:0]       conflict,
`ifdef IRRIGATION_TIMER_PAUSE_EN
    input  logic [ZONES-1:0]       pause,
`endif
    input  logic                   force_reset_n,
    input  logic [1:0]             preset_min_d,
    input  logic [3:0]             preset_min_u,
    output logic [2*ZONES-1:0]     minutes_d,
    output logic [4*ZONES-1:0]     minutes_u,
    output logic [3*ZONES-1:0]     seconds_d,
    output logic [4*ZONES-1:0]     seconds_u,
    output logic [ZONES-1:0]       zone_active,
    output logic [ZONES-1:0]       expired
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0]   pre_cnt;
    logic               tick;
    logic [ZONES-1:0]   hold;
    logic [MIN_U_W-1:0] load_min_u;
    logic               preset_nz;

`ifdef IRRIGATION_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = '0;
`endif

    assign tick       = (pre_cnt == CNT_W'(TICK_DIV - 1));
    assign load_min_u = (preset_min_u > MIN_U_W'(BCD_MAX)) ? MIN_U_W'(BCD_MAX) : preset_min_u;
    assign preset_nz  = (preset_min_d != '0) || (preset_min_u != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + CNT_W'(1);
    end

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        zone_state_t        state;
        logic               active;
        logic               exp_pulse;
        logic               clr;
        logic               load;
        logic               dec;
        logic               zero;
        logic               last;
        logic [MIN_D_W-1:0] md;
        logic [MIN_U_W-1:0] mu;
        logic [SEC_D_W-1:0] sd;
        logic [SEC_U_W-1:0] su;

        assign clr  = !irrigation_on[z] || conflict[z] || switch_pulse[z] || !force_reset_n;
        assign load = (state == IDLE) && !clr && preset_nz;
        assign dec  = (state == RUN) && tick && !hold[z] && !clr && !zero;

        bcd_mmss_down_counter u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clr),
            .load       (load),
            .dec        (dec),
            .load_min_d (preset_min_d),
            .load_min_u (load_min_u),
            .min_d      (md),
            .min_u      (mu),
            .sec_d      (sd),
            .sec_u      (su),
            .zero       (zero),
            .last       (last)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                active    <= 1'b0;
                exp_pulse <= 1'b0;
            end else begin
                exp_pulse <= 1'b0;
                if (clr) begin
                    state  <= IDLE;
                    active <= 1'b0;
                end else begin
                    case (state)
                        IDLE: if (preset_nz) begin
                            state  <= RUN;
                            active <= 1'b1;
                        end
                        RUN: if (dec && last) begin
                            state     <= DONE;
                            active    <= 1'b0;
                            exp_pulse <= 1'b1;
                        end
                        DONE: state <= DONE;
                        default: begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign minutes_d[MIN_D_W*z +: MIN_D_W] = md;
        assign minutes_u[MIN_U_W*z +: MIN_U_W] = mu;
        assign seconds_d[SEC_D_W*z +: SEC_D_W] = sd;
        assign seconds_u[SEC_U_W*z +: SEC_U_W] = su;
        assign zone_active[z] = active;
        assign expired[z]     = exp_pulse;
    end

endmodule

// File: tb/tb_irrigation_zone_timer.sv
// Scoreboard bench for irrigation_zone_timer (ZONES=2, TICK_DIV=4).
module tb_irrigation_zone_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] irrigation_on = '0;
    logic [1:0] switch_pulse = '0;
    logic [1:0] conflict = '0;
    logic [1:0] pause = '0;
    logic       force_reset_n = 1'b1;
    logic [1:0] preset_min_d = 2'd0;
    logic [3:0] preset_min_u = 4'd1;
    logic [3:0] minutes_d;
    logic [7:0] minutes_u;
    logic [5:0] seconds_d;
    logic [7:0] seconds_u;
    logic [1:0] zone_active;
    logic [1:0] expired;

    irrigation_zone_timer #(.ZONES(2), .TICK_DIV(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irrigation_on (irrigation_on),
        .switch_pulse  (switch_pulse),
        .conflict      (conflict),
`ifdef IRRIGATION_TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .force_reset_n (force_reset_n),
        .preset_min_d  (preset_min_d),
        .preset_min_u  (preset_min_u),
        .minutes_d     (minutes_d),
        .minutes_u     (minutes_u),
        .seconds_d     (seconds_d),
        .seconds_u     (seconds_u),
        .zone_active   (zone_active),
        .expired       (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    z;
        int    md, mu, sd, su;
        int    act;
        int    exp_n;
    } snap_t;

    snap_t sb[$];
    int    tests = 0;
    int    failed = 0;
    int    exp_seen[2] = '{0, 0};
    int    exp_want[2] = '{0, 0};
    int    tb_pre;

    // Independent prescaler model: the edge that leaves it at 0 is a tick edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_pre <= 0;
        else tb_pre <= (tb_pre == 3) ? 0 : tb_pre + 1;
    end

    always @(negedge clk) begin
        snap_t s;
        int gmd, gmu, gsd, gsu, gact;
        for (int z = 0; z < 2; z++) if (expired[z] === 1'b1) exp_seen[z]++;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            gmd = int'(minutes_d[2*s.z +: 2]);
            gmu = int'(minutes_u[4*s.z +: 4]);
            gsd = int'(seconds_d[3*s.z +: 3]);
            gsu = int'(seconds_u[4*s.z +: 4]);
            gact = int'(zone_active[s.z]);
            tests++;
            if (gmd != s.md || gmu != s.mu || gsd != s.sd || gsu != s.su ||
                gact != s.act || exp_seen[s.z] != s.exp_n) begin
                failed++;
                $display("FAIL %s zone%0d: got %0d%0d:%0d%0d active=%0d expired_n=%0d, want %0d%0d:%0d%0d active=%0d expired_n=%0d",
                         s.name, s.z, gmd, gmu, gsd, gsu, gact, exp_seen[s.z],
                         s.md, s.mu, s.sd, s.su, s.act, s.exp_n);
            end
        end
    end

    task automatic chk(input string name, input int z, input int md, input int mu,
                       input int sd, input int su, input int act);
        snap_t s;
        s.name = name; s.z = z; s.md = md; s.mu = mu; s.sd = sd; s.su = su;
        s.act = act; s.exp_n = exp_want[z];
        sb.push_back(s);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int n = 1);
        repeat (n) begin
            int guard = 0;
            do begin
                step();
                guard++;
            end while (tb_pre != 0 && guard < 8);
            if (tb_pre != 0) begin
                tests++;
                failed++;
                $display("FAIL tick_wait: got no tick within %0d cycles, want one within 4", guard);
            end
        end
    endtask

    initial begin
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0);
        chk("reset", 1, 0, 0, 0, 0, 0);
        #11 rst_n = 1'b1;

        // Zone0 full 1-minute run, DONE hold, restart after drop/raise
        step();
        irrigation_on[0] = 1'b1;
        step();
        chk("load_01_00", 0, 0, 1, 0, 0, 1);
        chk("zone1_idle", 1, 0, 0, 0, 0, 0);
        wait_tick();
        chk("first_dec", 0, 0, 0, 5, 9, 1);
        wait_tick(58);
        chk("at_00_01", 0, 0, 0, 0, 1, 1);
        wait_tick();
        exp_want[0] = 1;
        chk("expire", 0, 0, 0, 0, 0, 0);
        wait_tick(2);
        chk("done_hold", 0, 0, 0, 0, 0, 0);
        irrigation_on[0] = 1'b0;
        step();
        chk("off_idle", 0, 0, 0, 0, 0, 0);
        irrigation_on[0] = 1'b1;
        step();
        chk("restart", 0, 0, 1, 0, 0, 1);
        irrigation_on[0] = 1'b0;
        step();

        // Zone1 conflict on the tick edge at 00:01
        irrigation_on[1] = 1'b1;
        step();
        chk("z1_load", 1, 0, 1, 0, 0, 1);
        wait_tick(59);
        chk("z1_at_00_01", 1, 0, 0, 0, 1, 1);
        while (tb_pre != 3) step();
        conflict[1] = 1'b1;
        step();
        chk("conflict_clr", 1, 0, 0, 0, 0, 0);
        conflict[1] = 1'b0;
        step();
        chk("conflict_reload", 1, 0, 1, 0, 0, 1);
        irrigation_on[1] = 1'b0;
        step();

        // Force reset applies to both zones
        irrigation_on = 2'b11;
        step();
        wait_tick();
        chk("both_run0", 0, 0, 0, 5, 9, 1);
        chk("both_run1", 1, 0, 0, 5, 9, 1);
        force_reset_n = 1'b0;
        step();
        chk("force_clr0", 0, 0, 0, 0, 0, 0);
        chk("force_clr1", 1, 0, 0, 0, 0, 0);
        force_reset_n = 1'b1;
        step();
        chk("force_reload0", 0, 0, 1, 0, 0, 1);
        chk("force_reload1", 1, 0, 1, 0, 0, 1);

        // switch_pulse while held: one IDLE cycle then reload
        wait_tick();
        switch_pulse[0] = 1'b1;
        step();
        switch_pulse[0] = 1'b0;
        chk("switch_idle", 0, 0, 0, 0, 0, 0);
        step();
        chk("switch_reload", 0, 0, 1, 0, 0, 1);
        irrigation_on = 2'b00;
        step();

        // Preset clamp and tens borrow
        preset_min_d = 2'd3;
        preset_min_u = 4'd12;
        irrigation_on[0] = 1'b1;
        step();
        chk("clamp_39_00", 0, 3, 9, 0, 0, 1);
        wait_tick();
        chk("borrow_38_59", 0, 3, 8, 5, 9, 1);
        chk("z1_stays_off", 1, 0, 0, 0, 0, 0);
        irrigation_on[0] = 1'b0;
        step();

        // Preset 00 keeps zone in IDLE
        preset_min_d = 2'd0;
        preset_min_u = 4'd0;
        irrigation_on[1] = 1'b1;
        step(2);
        chk("preset_zero", 1, 0, 0, 0, 0, 0);
        irrigation_on[1] = 1'b0;
        preset_min_u = 4'd1;
        step();

`ifdef IRRIGATION_TIMER_PAUSE_EN
        irrigation_on[0] = 1'b1;
        step();
        wait_tick(30);
        chk("pause_at_00_30", 0, 0, 0, 3, 0, 1);
        pause[0] = 1'b1;
        wait_tick(10);
        chk("pause_hold", 0, 0, 0, 3, 0, 1);
        pause[0] = 1'b0;
        wait_tick();
        chk("pause_resume", 0, 0, 0, 2, 9, 1);
        irrigation_on[0] = 1'b0;
        step();
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_timer.md
Name: irrigation_zone_timer

Overview:
- Parametrised successor to the single-channel timer reset logic.
- Owns ZONES independent mm:ss BCD countdown timers, one per irrigation zone, plus the shared one-second prescaler.
- Evaluates the per-zone reset conditions internally (zone off, reached zero, forced reset, conflict, switch pulse) instead of emitting a bare reset.
- Sits between the zone/valve control FSMs and the display/valve drivers.

Parameters:
- ZONES, 2, number of independent zone timers (1..8).
- TICK_DIV, 50000000, clk cycles per one-second tick (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- irrigation_on  in  ZONES  per-zone irrigation request, level.
- switch_pulse  in  ZONES  one-cycle pulse on zone mode switch.
- conflict  in  ZONES  per-zone conflicting-values flag, level.
- force_reset_n  in  1  active-low forced reset from button, level; applies to all zones.
- preset_min_d  in  2  preset minutes tens, BCD 0..3; shared by all zones.
- preset_min_u  in  4  preset minutes units, BCD; shared by all zones.
- minutes_d  out  2*ZONES  per-zone minutes tens.
- minutes_u  out  4*ZONES  per-zone minutes units.
- seconds_d  out  3*ZONES  per-zone seconds tens, 0..5.
- seconds_u  out  4*ZONES  per-zone seconds units.
- zone_active  out  ZONES  high while the zone is in RUN.
- expired  out  ZONES  one-cycle pulse when the zone's countdown reaches 00:00.

Behaviour:
- Reset: all outputs 0, all zones in IDLE, prescaler 0.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1.
  - tick asserts for one cycle when the count is TICK_DIV-1.
  - Not affected by zone events.
- Per-zone clear condition: clr = !irrigation_on | conflict | switch_pulse | !force_reset_n. Evaluated every cycle.
- States: IDLE, RUN, DONE.
  - Any state, clr=1 -> IDLE next cycle; digits cleared to 00:00; zone_active=0. clr has priority over tick and over expiry.
  - IDLE, clr=0 and preset != 00 -> RUN; digits loaded with preset_min_d:preset_min_u:0:0 on the same edge.
  - IDLE, clr=0 and preset == 00 -> stay in IDLE.
  - RUN, tick and digits != 00:00 -> BCD decrement by one second.
  - RUN, decrement result == 00:00 -> DONE; expired pulses in the same cycle the digits become 00:00.
  - DONE -> holds 00:00; leaves only through clr. No auto-restart while irrigation_on stays high.
- BCD decrement:
  - seconds_u 0 -> 9 with borrow.
  - seconds_d 0 -> 5 with borrow.
  - minutes_u 0 -> 9 with borrow.
  - minutes_d decrements.
  - Widths fixed; no wrap below 00:00.
- Preset sanitisation at load: preset_min_u > 9 clamps to 9. preset_min_d is 2 bits, so no clamp is needed.
- switch_pulse while irrigation_on is held: IDLE for one cycle, then reload from preset and restart.
- Latency:
  - Load 1 cycle after clr falls.
  - First decrement at the next tick after load, 1..TICK_DIV cycles later.
- Zones are fully independent apart from force_reset_n, the preset and the tick. Loads on the same edge are allowed.

Optional Feature:
- Macro: IRRIGATION_TIMER_PAUSE_EN.
- With the macro:
  - Adds input pause [ZONES].
  - In RUN with pause=1, ticks are ignored and digits hold; zone_active stays 1.
  - clr still overrides pause.
  - pause in IDLE or DONE has no effect.
- Without the macro: no pause port; behaviour as above.

Decomposition:
- Package irrigation_timer_pkg holds:
  - zone_state_t enum {IDLE, RUN, DONE};
  - digit width constants MIN_D_W=2, MIN_U_W=4, SEC_D_W=3, SEC_U_W=4;
  - digit max constants SEC_D_MAX=5, BCD_MAX=9.
- Sub-module bcd_mmss_down_counter: one instance per zone via generate. Provides load, dec, clear inputs and a zero output.
- FSM and prescaler live in the top level.

Test Plan (TICK_DIV=4, ZONES=2):
- Zone0 on, preset 01 -> zone_active0=1 one cycle later with 01:00. After one tick 00:59; after 60 ticks 00:00 with expired0 pulsed once and DONE held.
- Zone1 running at 00:01, conflict1 asserted on the tick cycle -> IDLE, 00:00, no expired1 pulse.
- Both zones running, force_reset_n=0 for one cycle -> both cleared. Both reload preset and restart the cycle after force_reset_n returns to 1.
- Zone0 in DONE, irrigation_on0 held high -> stays 00:00. Drop irrigation_on0 then raise it -> reload and RUN.
- preset_min_u=12, preset_min_d=3 -> loads 39:00; tens borrow gives 38:59 after one tick.
- IRRIGATION_TIMER_PAUSE_EN defined, pause0=1 for 10 ticks at 00:30 -> holds 00:30; resumes 00:29 on the first tick after pause0 drops.
